channel_rr_merger: RTL and testbench

Round-robin merger that drains up to PORTS upstream `blocking_channel` instances into one downstream `blocking_channel`, tagging each message with its source index. It sits between a processing unit's per-neighbour input channels and the unit's single message-consumption FIFO. It sustains one message per clock through a single registered output stage. The only combinational path from downstream back to upstream is `out_is_full` to `in_is_taken`, one arbiter deep; `out_is_full` itself is a registered FIFO flag.

---
 rtl/channel_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 75 +++++++
 rtl/channel_rr_merger.sv | 115 +++++++++++
 tb/tb_channel_rr_merger.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// channel_pkg
// Shared helpers for the blocking_channel merger family.
// Contents:
//   src_width(ports) - width of a source index able to name `ports` ports,
//                      never less than one bit.
package channel_pkg;

  function automatic int src_width(input int ports);
    return (ports <= 2) ? 1 : $clog2(ports);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter with its own rotating priority pointer. The search for
// a grant starts at ptr and wraps modulo PORTS; when `advance` is high the
// pointer moves to one past the granted port so that port becomes lowest
// priority next time.
// Ports:
//   clk, reset, initialize - clock, synchronous active-high resets (both clear ptr)
//   req        [PORTS]     - request vector
//   advance                - commit the current grant and rotate the pointer
//   grant      [PORTS]     - combinational one-hot grant (zero when no request)
//   grant_idx  [SRC_W]     - encoded index of grant
//   any_req                - at least one request is present
//   ptr        [SRC_W]     - current priority pointer (registered)
module rr_arbiter
  import channel_pkg::*;
#(
  parameter  int PORTS = 4,
  localparam int SRC_W = src_width(PORTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             initialize,
  input  logic [PORTS-1:0] req,
  input  logic             advance,
  output logic [PORTS-1:0] grant,
  output logic [SRC_W-1:0] grant_idx,
  output logic             any_req,
  output logic [SRC_W-1:0] ptr
);

  logic [SRC_W-1:0] ptr_q;
  logic [SRC_W-1:0] ptr_d;
  logic             found;
  logic [SRC_W-1:0] cand;

  // Walk the ports in priority order starting at ptr; the first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    any_req   = |req;
    for (int k = 0; k < PORTS; k++) begin
      cand = SRC_W'((int'(ptr_q) + k) % PORTS);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next pointer is one past the winner, wrapping at PORTS (which need not be a power of two).
  always_comb begin
    ptr_d = ptr_q;
    if (advance && any_req) begin
      if (grant_idx == SRC_W'(PORTS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + SRC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || initialize) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/channel_rr_merger.sv
// channel_rr_merger
// Drains up to PORTS upstream blocking channels into one downstream channel,
// one message per clock, tagging each message with the port it came from.
// A single registered output stage holds the message; it may be refilled in
// the same cycle its contents are accepted downstream.
// Ports:
//   clk, reset, initialize    - clock, synchronous active-high clears
//   in_data   [PORTS*WIDTH]   - packed upstream payloads, port i at [i*WIDTH +: WIDTH]
//   in_valid  [PORTS]         - upstream message present
//   in_is_taken [PORTS]       - one-hot pop strobe back to upstream
//   out_data  [WIDTH]         - held payload
//   out_src   [SRC_W]         - source port of the held payload
//   out_valid                 - held payload valid
//   out_is_full               - downstream full flag (registered in the consumer)
//   idle                      - registered: stage empty and nothing offered last cycle
module channel_rr_merger
  import channel_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int PORTS = 4,
  localparam int SRC_W = src_width(PORTS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   initialize,
  input  logic [PORTS*WIDTH-1:0] in_data,
  input  logic [PORTS-1:0]       in_valid,
  output logic [PORTS-1:0]       in_is_taken,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  output logic                   out_valid,
  input  logic                   out_is_full,
  output logic                   idle
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;
  logic             idle_q, idle_d;

  logic [PORTS-1:0] grant;
  logic [SRC_W-1:0] grant_idx;
  logic             any_req;
  logic [SRC_W-1:0] ptr;
  logic             load_en;
  logic             take;
  logic [WIDTH-1:0] sel_data;

  // The stage can accept a new message when it is empty or being drained this
  // cycle. A clear blocks loading so nothing is popped upstream while resetting.
  assign load_en = (!out_valid_q || !out_is_full) && !(reset || initialize);
  assign take    = load_en && any_req;

  rr_arbiter #(
    .PORTS (PORTS)
  ) u_arbiter (
    .clk        (clk),
    .reset      (reset),
    .initialize (initialize),
    .req        (in_valid),
    .advance    (take),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_req    (any_req),
    .ptr        (ptr)
  );

  assign in_is_taken = grant & {PORTS{load_en}};

  // Grant is one-hot, so an OR of masked payloads selects the winner.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage: reload on load_en, otherwise hold (stalled by backpressure).
  // With nothing offered, only the valid bit drops; payload and tag keep their value.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load_en) begin
      out_valid_d = any_req;
      if (any_req) begin
        out_data_d = sel_data;
        out_src_d  = grant_idx;
      end
    end
    idle_d = !out_valid_q && !(|in_valid);
  end

  always_ff @(posedge clk) begin
    if (reset || initialize) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      idle_q      <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      idle_q      <= idle_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_channel_rr_merger.sv
// tb_channel_rr_merger
// Directed bench for channel_rr_merger (WIDTH=8, PORTS=4). Each stimulus step
// states the hand-derived pop strobe; every expected pop pushes the message the
// downstream side should later receive, and an independent monitor pops and
// compares on each downstream transfer.
module tb_channel_rr_merger;

  localparam int WIDTH = 8;
  localparam int PORTS = 4;
  localparam int SRC_W = 2;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [WIDTH-1:0] data;
  } msg_t;

  logic                   clk;
  logic                   reset;
  logic                   initialize;
  logic [PORTS*WIDTH-1:0] in_data;
  logic [PORTS-1:0]       in_valid;
  logic [PORTS-1:0]       in_is_taken;
  logic [WIDTH-1:0]       out_data;
  logic [SRC_W-1:0]       out_src;
  logic                   out_valid;
  logic                   out_is_full;
  logic                   idle;

  logic [WIDTH-1:0] din [PORTS];
  msg_t             expQ [$];
  int               checks;
  int               errors;

  channel_rr_merger #(
    .WIDTH (WIDTH),
    .PORTS (PORTS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .initialize  (initialize),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_is_taken (in_is_taken),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_valid   (out_valid),
    .out_is_full (out_is_full),
    .idle        (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      in_data[i*WIDTH +: WIDTH] = din[i];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, check the pop strobe, and record expected output.
  task automatic applyStimulus(input logic [PORTS-1:0] v, input logic full,
                               input logic rst, input logic init,
                               input logic [PORTS-1:0] expTaken);
    msg_t m;
    @(posedge clk);
    #1;
    in_valid    = v;
    out_is_full = full;
    reset       = rst;
    initialize  = init;
    #1;
    checkOutput("in_is_taken", {28'd0, in_is_taken}, {28'd0, expTaken});
    for (int i = 0; i < PORTS; i++) begin
      if (expTaken[i]) begin
        m.src  = SRC_W'(i);
        m.data = din[i];
        expQ.push_back(m);
      end
    end
  endtask

  // Downstream monitor: a transfer happens when valid and not full.
  always @(negedge clk) begin
    msg_t m;
    if (!reset && !initialize && out_valid === 1'b1 && out_is_full === 1'b0) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_msg: got data 0x%0h src %0d, expected none", out_data, out_src);
      end else begin
        m = expQ.pop_front();
        checkOutput("out_data", {24'd0, out_data}, {24'd0, m.data});
        checkOutput("out_src", {30'd0, out_src}, {30'd0, m.src});
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    initialize  = 1'b0;
    in_valid    = 4'b1111;
    out_is_full = 1'b0;
    din[0] = 8'hC3;
    din[1] = 8'h5A;
    din[2] = 8'hA5;
    din[3] = 8'h3C;

    $display("[TB] reset with all ports valid");
    applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", {24'd0, out_data}, 32'd0);
    checkOutput("rst_out_src", {30'd0, out_src}, 32'd0);
    checkOutput("rst_idle", {31'd0, idle}, 32'd1);

    $display("[TB] single message on port 2");
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("single_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("single_data", {24'd0, out_data}, 32'hA5);
    checkOutput("single_src", {30'd0, out_src}, 32'd2);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("single_drop", {31'd0, out_valid}, 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("quiet_idle", {31'd0, idle}, 32'd1);

    $display("[TB] initialize then full throughput");
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0010);
    checkOutput("tp_valid0", {31'd0, out_valid}, 32'd1);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0100);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 4'b1000);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0010);
    checkOutput("tp_idle", {31'd0, idle}, 32'd0);

    $display("[TB] wrap-around from ptr 2");
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0, 4'b1000);
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0, 4'b0001);
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0, 4'b0010);

    $display("[TB] backpressure");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000);
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_data", {24'd0, out_data}, 32'h5A);
      checkOutput("bp_src", {30'd0, out_src}, 32'd1);
    end
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0100);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("bp_next_src", {30'd0, out_src}, 32'd2);

    $display("[TB] initialize while stalled");
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000);
    checkOutput("init_held_valid", {31'd0, out_valid}, 32'd1);
    // The held port-3 message is discarded by initialize.
    void'(expQ.pop_back());
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001);
    checkOutput("init_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("init_idle", {31'd0, idle}, 32'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("init_next_src", {30'd0, out_src}, 32'd0);

    for (int c = 0; c < 20 && expQ.size() != 0; c++) begin
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("drain_empty", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
